// File: rtl/digit_scan.sv
// digit_scan: scan controller for a multiplexed 4-digit display.
// It holds four 4-bit digit registers and steps the mux select through
// them. Each digit slot starts with a short dead interval, and leading
// zeros can optionally be suppressed.
//
// Interface contract: there is no handshake. Every output is valid every
// cycle. wr_en is a single-cycle strobe, sampled on every rising edge,
// and it is never back-pressured.
module digit_scan #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       lz_blank,
  output logic [3:0] data_0,
  output logic [3:0] data_1,
  output logic [3:0] data_2,
  output logic [3:0] data_3,
  output logic [1:0] sel,
  output logic [3:0] digit_en_n,
  output logic       blank,
  output logic       slot_done
);

  localparam int            CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // The scan has no idle state: it cycles through the four slots forever.
  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2,
    SLOT_3 = 2'd3
  } slot_e;

  slot_e         slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    d_q [4];
  logic [3:0]    d_d [4];
  logic          dead;
  logic          z3, z32, z321;
  logic [3:0]    supp;

  // Digit register write: exactly one register is updated per strobe.
  always_comb begin
    d_d = d_q;
    if (wr_en) d_d[wr_addr] = wr_data;
  end

  // Prescaler: wrap on the last cycle of a slot.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (slot_done) cnt_d = '0;
  end

  // Slot sequencing: advance to the next digit at the end of each slot.
  always_comb begin
    slot_d = slot_q;
    if (slot_done) begin
      unique case (slot_q)
        SLOT_0:  slot_d = SLOT_1;
        SLOT_1:  slot_d = SLOT_2;
        SLOT_2:  slot_d = SLOT_3;
        SLOT_3:  slot_d = SLOT_0;
        default: slot_d = SLOT_0;
      endcase
    end
  end

  // State registers. Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= SLOT_0;
      cnt_q  <= '0;
      for (int i = 0; i < 4; i++) d_q[i] <= 4'h0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
    end
  end

  // Dead interval at the start of each slot. It is absent when BLANK is 0.
  generate
    if (BLANK > 0) begin : g_dead
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
      assign dead = (cnt_q < BLANK_C);
    end else begin : g_no_dead
      assign dead = 1'b0;
    end
  endgenerate

  // A digit is suppressed when lz_blank is high, the digit is not digit 0,
  // and that digit plus every more significant digit is zero.
  assign z3   = (d_q[3] == 4'h0);
  assign z32  = z3 & (d_q[2] == 4'h0);
  assign z321 = z32 & (d_q[1] == 4'h0);
  assign supp = {lz_blank & z3, lz_blank & z32, lz_blank & z321, 1'b0};

  assign slot_done = (cnt_q == CNT_LAST);
  assign blank     = dead | supp[slot_q];
  assign sel       = slot_q;
  assign data_0    = d_q[0];
  assign data_1    = d_q[1];
  assign data_2    = d_q[2];
  assign data_3    = d_q[3];

  // Active-low one-hot enable for the selected digit, or all off when blank.
  always_comb begin
    digit_en_n = 4'hF;
    if (!blank) digit_en_n[slot_q] = 1'b0;
  end

endmodule

// File: doc/digit_scan.md
# digit_scan

Multiplexed 4-digit display scan controller that sits directly upstream of the 4-bit 4:1 digit mux (`mux4`). It holds four 4-bit digit registers and presents them on `data_0`..`data_3` for the mux data inputs. It also steps the 2-bit `sel` that picks the displayed digit and drives active-low digit enables with a dead interval between digits and optional leading-zero blanking.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, default 4: dead cycles at the start of each slot with all digits off; legal range 0 ≤ BLANK < PRESCALE.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `wr_en` in 1: write strobe for a digit register.
- `wr_addr` in 2: digit register index, 0 = least significant.
- `wr_data` in 4: value to write.
- `lz_blank` in 1: when high, suppress leading zeros.
- `data_0`..`data_3` out 4 each: digit register contents; wire these to the mux data inputs.
- `sel` out 2: current digit index; wire this to the mux `sel`.
- `digit_en_n` out 4: active-low digit enables; at most one bit is low.
- `blank` out 1: high when no digit is enabled this cycle.
- `slot_done` out 1: one-cycle pulse on the last cycle of each slot.

## Operation
- **State registers:**
  - `d[0..3]`, 4 bits each.
  - `cnt`, prescale counter 0..PRESCALE-1, width ceil(log2(PRESCALE)).
  - `sel`, 2 bits.
- **Writes:**
  - When `wr_en` is high at a clock edge, `d[wr_addr] <= wr_data`.
  - The new value appears on `data_<wr_addr>` in the next cycle.
  - Only one register is written per cycle; the others hold.
- **Prescaler:**
  - `cnt` increments every cycle.
  - When `cnt == PRESCALE-1`, it wraps to 0 and `sel` increments modulo 4 (3 → 0).
- **Scan states:** the slot sequence is `sel` = 0 → 1 → 2 → 3 → 0. There is no idle state; scanning runs continuously out of reset.
- **Suppression:** digit k is suppressed when all of the following hold:
  - `lz_blank` = 1,
  - k ≠ 0,
  - `d[k]`..`d[3]` are all zero.
  
  Digit 0 is never suppressed, so value 0 shows as a single "0".
- **Decode (combinational from registered state):**
  - `blank` = (`cnt` < BLANK) OR (digit `sel` is suppressed).
  - `digit_en_n` = 4'b1111 when `blank` is high; otherwise it is all ones except bit `sel`, which is 0.
  - `slot_done` = (`cnt` == PRESCALE-1).
- **Write during display:** writing the digit currently selected changes the mux output from the next cycle. The slot is not restarted and there is no tearing protection.
- **`lz_blank` changes:** take effect in the same cycle (combinational path).

## Timing
- **Reset values:** synchronous; the values below hold on the cycle after `reset` is sampled high.
  - `d[0..3]` = 0, `cnt` = 0, `sel` = 0.
  - `digit_en_n` = 4'b1111 if BLANK > 0; otherwise 4'b1110.
  - `blank` = 1 if BLANK > 0; otherwise 0.
  - `slot_done` = 0.
- **Reset priority:**
  - Reset overrides `wr_en`; a write in the reset cycle is dropped.
  - Reset mid-slot restarts the scan at `sel` = 0, `cnt` = 0.
- **Slot timing:**
  - One slot lasts exactly PRESCALE cycles; a full scan lasts 4·PRESCALE cycles.
  - `sel` changes on the edge following the `slot_done` cycle.
  - `sel` is stable for the whole slot, including the dead interval, so the mux output is settled before the enable asserts.
- **Enable window:** within a slot, the enable (if not suppressed) is low for cycles BLANK..PRESCALE-1, i.e. PRESCALE-BLANK cycles.
- **Write latency:** 1 cycle from `wr_en` edge to `data_k`. The suppression decision uses the updated value in that same following cycle.
- **Output timing:** all outputs are valid every cycle; there is no handshake.

## Test plan
- **Reset and idle scan** (PRESCALE=8, BLANK=2): assert `reset` for 2 cycles, then release.
  - `data_0`..`data_3` = 0 and `sel` = 0.
  - `digit_en_n` = 1111 for 2 cycles, then 1110 for 6 cycles.
  - `slot_done` pulses at cycle 7 and `sel` = 1 at cycle 8.
  - After 32 cycles `sel` has wrapped 3 → 0.
- **Writes:** write 4'h1, 4'h2, 4'h3, 4'h4 to addresses 0..3 on consecutive cycles.
  - Each `data_k` updates exactly one cycle after its write; the other registers are unchanged.
  - Across one scan, the enabled digit k coincides with `sel` = k.
- **Leading-zero blank:** load `d` = {3:0, 2:0, 1:5, 0:0}, `lz_blank` = 1.
  - In slots 2 and 3, `digit_en_n` = 1111 and `blank` = 1 for all 8 cycles.
  - Slots 1 and 0 enable normally.
  - With all digits 0, only digit 0 is enabled.
  - With `lz_blank` = 0, all four digits are enabled.
- **Write to the displayed digit:** during slot 2 at `cnt` = 4, write `d[2]` = 4'h9.
  - `data_2` = 9 from `cnt` = 5.
  - `sel` stays 2 and the slot is not restarted.
- **Reset mid-operation:** during `sel` = 3, `cnt` = 5, assert `reset` together with `wr_en` (addr 1, data 4'hF).
  - Next cycle: `sel` = 0, `cnt` = 0, all `data` = 0 (write dropped), `digit_en_n` = 1111.
- **BLANK=0 boundary** (PRESCALE=2):
  - `digit_en_n` is never 1111 with nonzero data.
  - `sel` advances every 2 cycles.
  - `slot_done` pulses every other cycle.
